// File: rtl/aes128_pipe_encrypt.sv
// aes128_pipe_encrypt: fully pipelined AES-128 encryptor, one block per cycle, global valid/ready stall.
// S0 holds the whitened state and cipher key; S1..S(NSTAGE) each apply ROUNDS_PER_STAGE rounds.
module aes128_pipe_encrypt #(
    parameter int ROUNDS_PER_STAGE = 2,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [127:0]     in_data,
    input  logic [127:0]     in_key,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);
    localparam int NSTAGE = 10 / ROUNDS_PER_STAGE;

    if (ROUNDS_PER_STAGE != 1 && ROUNDS_PER_STAGE != 2 && ROUNDS_PER_STAGE != 5 && ROUNDS_PER_STAGE != 10) begin : g_bad_rps
        $error("aes128_pipe_encrypt: ROUNDS_PER_STAGE must be 1, 2, 5 or 10");
    end
    if (TAG_W < 1 || TAG_W > 64) begin : g_bad_tag
        $error("aes128_pipe_encrypt: TAG_W must be in 1..64");
    end

    localparam logic [2047:0] SBOX_T = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    localparam logic [7:0] RCON [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    // entry x sits at bit offset 8*(255-x)+7 of the packed table
    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_T[{~x, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] key_next(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3;
        w0 = k[127:96] ^ sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
    endfunction

    // byte i of the state is row i%4, column i/4; ShiftRows pulls row r from column (c+r)%4
    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k, input logic last);
        logic [127:0] t, m;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[127 - 8*(4*c + r) -: 8] = sbox(s[127 - 8*(4*((c + r) % 4) + r) -: 8]);
        for (int c = 0; c < 4; c++)
            m[127 - 32*c -: 32] = last ? t[127 - 32*c -: 32] : mix_col(t[127 - 32*c -: 32]);
        return m ^ k;
    endfunction

    function automatic logic [255:0] stage_fn(input logic [255:0] sk_in, input int k);
        logic [127:0] s, kk;
        int r;
        {s, kk} = sk_in;
        for (int j = 0; j < ROUNDS_PER_STAGE; j++) begin
            r = (k - 1) * ROUNDS_PER_STAGE + j + 1;
            kk = key_next(kk, RCON[r]);
            s = aes_round(s, kk, r == 10);
        end
        return {s, kk};
    endfunction

    logic [NSTAGE:0]    vld;
    logic [255:0]       sk  [0:NSTAGE];
    logic [TAG_W-1:0]   tg  [0:NSTAGE];
    logic [255:0]       nxt [1:NSTAGE];
    logic               advance;

    assign advance   = !vld[NSTAGE] | out_ready;
    assign in_ready  = advance;
    assign out_valid = vld[NSTAGE];
    assign out_data  = sk[NSTAGE][255:128];
    assign out_tag   = tg[NSTAGE];
    assign busy      = |vld;

    always_comb begin
        for (int k = 1; k <= NSTAGE; k++)
            nxt[k] = stage_fn(sk[k-1], k);
    end

    // bubbles travel with the pipe; a stall freezes every stage at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld <= '0;
            for (int k = 0; k <= NSTAGE; k++) begin
                sk[k] <= '0;
                tg[k] <= '0;
            end
        end else if (advance) begin
            vld   <= {vld[NSTAGE-1:0], in_valid};
            sk[0] <= {in_data ^ in_key, in_key};
            tg[0] <= in_tag;
            for (int k = 1; k <= NSTAGE; k++) begin
                sk[k] <= nxt[k];
                tg[k] <= tg[k-1];
            end
        end
    end
endmodule

// File: tb/tb_aes128_pipe_encrypt.sv
// tb_aes128_pipe_encrypt: scoreboard bench for the pipelined AES-128 core.
// Expected ciphertexts come from a byte-array AES model whose S-box is derived from GF(2^8) inversion.
module tb_aes128_pipe_encrypt;
    localparam int RPS = 2;
    localparam int TAG_W = 8;
    localparam int NSTAGE = 10 / RPS;

    logic             clk = 0;
    logic             reset = 1;
    logic             in_valid = 0;
    logic             in_ready;
    logic [127:0]     in_data = '0;
    logic [127:0]     in_key = '0;
    logic [TAG_W-1:0] in_tag = '0;
    logic             out_valid;
    logic             out_ready = 1;
    logic [127:0]     out_data;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    logic             aux_ready [3];
    logic             aux_valid [3];
    logic [127:0]     aux_data  [3];
    logic [TAG_W-1:0] aux_tag   [3];
    logic             aux_busy  [3];

    always #5 clk = ~clk;

    aes128_pipe_encrypt #(.ROUNDS_PER_STAGE(RPS), .TAG_W(TAG_W)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_key(in_key), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .busy(busy)
    );

    // the other legal stage depths, fed the same inputs and never stalled
    for (genvar g = 0; g < 3; g++) begin : g_aux
        aes128_pipe_encrypt #(.ROUNDS_PER_STAGE(g == 0 ? 1 : g == 1 ? 5 : 10), .TAG_W(TAG_W)) u_aux (
            .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(aux_ready[g]),
            .in_data(in_data), .in_key(in_key), .in_tag(in_tag),
            .out_valid(aux_valid[g]), .out_ready(1'b1), .out_data(aux_data[g]),
            .out_tag(aux_tag[g]), .busy(aux_busy[g])
        );
    end

    typedef struct {
        logic [127:0]     d;
        logic [TAG_W-1:0] t;
    } exp_t;

    exp_t       sbq[$];
    int         out_cyc[$];
    int         checks = 0;
    int         passes = 0;
    int         cyc = 0;
    int         acc_cyc = 0;
    logic       rand_ready = 0;
    logic [7:0] sb [256];

    always @(posedge clk) cyc++;

    always @(posedge clk) if (rand_ready) begin
        #1;
        out_ready = 1'($urandom_range(0, 1));
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        for (int i = 0; i < n; i++) b = {b[6:0], b[7]};
        return b;
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
        logic [31:0]  w [44];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   a [4];
        logic [31:0]  tmp;
        logic [7:0]   rc;
        logic [127:0] res;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rc, 24'h0};
                rc = gm(rc, 8'h02);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ w[i/4][31 - 8*(i%4) -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int j = 0; j < 4; j++) s[4*c + j] = t[4*((c + j) % 4) + j];
            if (r < 10)
                for (int c = 0; c < 4; c++) begin
                    for (int j = 0; j < 4; j++) a[j] = s[4*c + j];
                    for (int j = 0; j < 4; j++)
                        s[4*c + j] = gm(8'h02, a[j]) ^ gm(8'h03, a[(j+1)%4]) ^ a[(j+2)%4] ^ a[(j+3)%4];
                end
            for (int i = 0; i < 16; i++) s[i] ^= w[4*r + i/4][31 - 8*(i%4) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic send(input logic [127:0] d, input logic [127:0] k, input logic [TAG_W-1:0] t, input logic [127:0] e);
        int n = 0;
        in_valid = 1;
        in_data = d;
        in_key = k;
        in_tag = t;
        @(negedge clk);
        while (!in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (in_ready) begin
            sbq.push_back('{e, t});
            acc_cyc = cyc;
        end else check("accept_timeout", in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 0;
    endtask

    task automatic idle(input int n);
        in_valid = 0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // monitor: handshake rule, stall stability, and in-order scoreboard pops
    logic             prev_stall = 0;
    logic [127:0]     prev_d;
    logic [TAG_W-1:0] prev_t;
    always @(negedge clk) begin
        exp_t e;
        if (reset) prev_stall = 0;
        else begin
            check("in_ready", in_ready, !out_valid || out_ready);
            if (prev_stall) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, prev_d);
                check("hold_tag", out_tag, prev_t);
            end
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) check("unexpected_out", out_valid, 0);
                else begin
                    e = sbq.pop_front();
                    check("out_data", out_data, e.d);
                    check("out_tag", out_tag, e.t);
                    out_cyc.push_back(cyc);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_d = out_data;
            prev_t = out_tag;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    logic [127:0] vk  [2] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h2b7e151628aed2a6abf7158809cf4f3c};
    logic [127:0] vpt [2] = '{128'h00112233445566778899aabbccddeeff, 128'h3243f6a8885a308d313198a2e0370734};
    logic [127:0] vct [2] = '{128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h3925841d02dc09fbdc118597196a0b32};
    int           aux_lat [3] = '{11, 3, 2};

    initial begin
        logic [127:0] d, k;
        logic [7:0]   inv;
        int           hits;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_tag", out_tag, 0);
        reset = 0;
        #1;
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // FIPS-197 vectors on every stage depth, with exact latency
        for (int v = 0; v < 2; v++) begin
            logic       seen_m;
            logic [2:0] seen;
            seen_m = 0;
            seen = '0;
            send(vpt[v], vk[v], 8'h5a, vct[v]);
            repeat (15) begin
                @(negedge clk);
                if (out_valid && !seen_m) begin
                    seen_m = 1;
                    check("lat_main", cyc - acc_cyc, NSTAGE + 1);
                end
                for (int g = 0; g < 3; g++)
                    if (aux_valid[g] && !seen[g]) begin
                        seen[g] = 1;
                        check("aux_data", aux_data[g], vct[v]);
                        check("aux_tag", aux_tag[g], 8'h5a);
                        check("aux_lat", cyc - acc_cyc, aux_lat[g]);
                    end
            end
            check("vector_seen", {seen_m, seen}, 4'hf);
            @(posedge clk);
            #1;
        end

        // streaming: 64 back-to-back blocks, key changes every 4 blocks
        out_cyc.delete();
        k = rnd128();
        for (int i = 0; i < 64; i++) begin
            if (i % 4 == 0) k = rnd128();
            d = rnd128();
            send(d, k, TAG_W'(i), aes_ref(d, k));
        end
        idle(NSTAGE + 3);
        check("stream_count", out_cyc.size(), 64);
        if (out_cyc.size() == 64) check("stream_span", out_cyc[63] - out_cyc[0], 63);

        // random backpressure over 200 blocks
        rand_ready = 1;
        for (int i = 0; i < 200; i++) begin
            d = rnd128();
            k = rnd128();
            send(d, k, TAG_W'($urandom), aes_ref(d, k));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        rand_ready = 0;
        out_ready = 1;
        idle(3 * NSTAGE + 5);
        check("bp_drained", sbq.size(), 0);

        // reset with the pipe full and the output stalled
        for (int i = 0; i <= NSTAGE; i++) begin
            d = rnd128();
            send(d, vk[0], TAG_W'(i), aes_ref(d, vk[0]));
        end
        out_ready = 0;
        #2;
        check("pre_rst_valid", out_valid, 1);
        check("pre_rst_busy", busy, 1);
        reset = 1;
        #1;
        check("async_out_valid", out_valid, 0);
        check("async_busy", busy, 0);
        check("async_out_data", out_data, 0);
        check("async_out_tag", out_tag, 0);
        sbq.delete();
        @(posedge clk);
        #1;
        reset = 0;
        out_ready = 1;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        hits = 0;
        repeat (2 * NSTAGE + 2) begin
            @(negedge clk);
            if (out_valid) hits++;
        end
        check("no_out_after_rst", hits, 0);
        @(posedge clk);
        #1;
        send(vpt[1], vk[1], 8'h3c, vct[1]);
        hits = 0;
        while (!out_valid && hits < 40) begin
            @(negedge clk);
            hits++;
        end
        check("post_rst_lat", cyc - acc_cyc, NSTAGE + 1);
        @(posedge clk);
        #1;

        // sparse input every third cycle
        out_cyc.delete();
        for (int i = 0; i < 10; i++) begin
            d = rnd128();
            k = rnd128();
            send(d, k, TAG_W'(i + 100), aes_ref(d, k));
            idle(2);
        end
        idle(NSTAGE + 3);
        check("sparse_count", out_cyc.size(), 10);
        for (int i = 1; i < out_cyc.size(); i++) check("sparse_gap", out_cyc[i] - out_cyc[i-1], 3);
        check("sparse_busy", busy, 0);
        check("final_drained", sbq.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
